// File: rtl/conv_output_packer.sv
// rtl/conv_output_packer.sv - packs convolution output elements into lane words behind a word FIFO
module conv_output_packer #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int PACK               = 4,
  parameter int FIFO_DEPTH         = 8,
  localparam int XW  = $clog2(FEATURE_MAP_WIDTH),
  localparam int YW  = $clog2(FEATURE_MAP_HEIGHT),
  localparam int CW  = $clog2(OUTPUT_NB_CHANNELS),
  localparam int LVW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  input  logic [XW-1:0]                in_x,
  input  logic [YW-1:0]                in_y,
  input  logic [CW-1:0]                in_ch,
  input  logic                         relu_en,
  input  logic                         flush,
  output logic [PACK*DATA_WIDTH-1:0]   out_data,
  output logic [PACK-1:0]              out_keep,
  output logic [XW-1:0]                out_x,
  output logic [YW-1:0]                out_y,
  output logic [CW-1:0]                out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [LVW-1:0]               fifo_level
);

  localparam int LW  = $clog2(PACK);
  localparam int LW1 = LW + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int WW  = PACK * DATA_WIDTH;
  localparam int EW  = WW + PACK + XW + YW + CW;

  // Packing stage state: lanes gathered so far and the lane-0 coordinates
  logic [LW-1:0]         lane_cnt;
  logic [WW-1:0]         acc;
  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [CW-1:0]         ch_q;

  // FIFO state
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LVW-1:0]        count;
  logic                  ovf_q;

  // Combinational view of the word as it stands after this edge's sample
  logic [DATA_WIDTH-1:0] elem;
  logic [WW-1:0]         word_next;
  logic [XW-1:0]         x_next;
  logic [YW-1:0]         y_next;
  logic [CW-1:0]         ch_next;
  logic [LW1-1:0]        n_next;
  logic [PACK-1:0]       push_keep;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;

  // Optional ReLU then merge the incoming element into its lane
  always_comb begin
    elem      = (relu_en && in_data[DATA_WIDTH-1]) ? '0 : in_data;
    word_next = acc;
    for (int i = 0; i < PACK; i++) begin
      if (in_valid && lane_cnt == LW'(i)) begin
        word_next[i*DATA_WIDTH +: DATA_WIDTH] = elem;
      end
    end
    if (in_valid && lane_cnt == '0) begin
      x_next  = in_x;
      y_next  = in_y;
      ch_next = in_ch;
    end else begin
      x_next  = x_q;
      y_next  = y_q;
      ch_next = ch_q;
    end
    n_next = {1'b0, lane_cnt} + LW1'(in_valid);
    for (int i = 0; i < PACK; i++) begin
      push_keep[i] = (LW1'(i) < n_next);
    end
    // A full word always pushes; a flush pushes only if something is pending,
    // so a flush coinciding with the last element still yields one word.
    push = (n_next == LW1'(PACK)) || (flush && n_next != '0);
  end

  // FIFO handshake decode; a push into a full FIFO survives only alongside a pop
  always_comb begin
    out_valid = (count != '0);
    full      = (count == LVW'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    push_ok   = push && (!full || pop);
  end

  // Lane counter, lane accumulator and held coordinates
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      acc      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ch_q     <= '0;
    end else begin
      x_q  <= x_next;
      y_q  <= y_next;
      ch_q <= ch_next;
      if (push) begin
        // Clearing keeps unused lanes of a later partial word at zero
        lane_cnt <= '0;
        acc      <= '0;
      end else begin
        lane_cnt <= n_next[LW-1:0];
        acc      <= word_next;
      end
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= {word_next, push_keep, x_next, y_next, ch_next};
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  // Head-of-FIFO payload, forced to zero while empty
  always_comb begin
    if (out_valid) begin
      {out_data, out_keep, out_x, out_y, out_ch} = mem[rd_ptr];
    end else begin
      {out_data, out_keep, out_x, out_y, out_ch} = '0;
    end
    overflow   = ovf_q;
    fifo_level = count;
  end

endmodule

// File: tb/tb_conv_output_packer.sv
// tb/tb_conv_output_packer.sv - self-checking bench for conv_output_packer
module tb_conv_output_packer;

  localparam int DW = 16;
  localparam int PACK = 4;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [DW-1:0] in_data;
  logic              in_valid;
  logic [6:0]        in_x;
  logic [6:0]        in_y;
  logic [5:0]        in_ch;
  logic              relu_en;
  logic              flush;
  logic [63:0]       out_data;
  logic [3:0]        out_keep;
  logic [6:0]        out_x;
  logic [6:0]        out_y;
  logic [5:0]        out_ch;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic [3:0]        fifo_level;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  keep;
    int          x;
    int          y;
    int          ch;
  } word_t;

  word_t mq[$];
  int    part[$];
  int    px, py, pch;
  bit    m_ovf;

  conv_output_packer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_x(in_x), .in_y(in_y), .in_ch(in_ch), .relu_en(relu_en), .flush(flush),
    .out_data(out_data), .out_keep(out_keep), .out_x(out_x), .out_y(out_y),
    .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: elements collect in a list; a word forms when the list
  // reaches PACK entries or a flush arrives with a non-empty list.
  task automatic model_edge();
    bit    do_pop;
    bit    was_full;
    word_t w;
    int    v;
    if (rst) begin
      mq.delete();
      part.delete();
      m_ovf = 0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() > 0) && out_ready;
    if (in_valid) begin
      if (part.size() == 0) begin
        px = in_x; py = in_y; pch = in_ch;
      end
      v = int'(in_data);
      if (relu_en && v < 0) v = 0;
      part.push_back(v);
    end
    if (do_pop) void'(mq.pop_front());
    if (part.size() == PACK || (flush && part.size() > 0)) begin
      w.data = '0;
      w.keep = '0;
      for (int i = 0; i < part.size(); i++) begin
        w.data = w.data | (64'(part[i] & 16'hFFFF) << (16 * i));
        w.keep[i] = 1'b1;
      end
      w.x = px; w.y = py; w.ch = pch;
      if (!was_full || do_pop) mq.push_back(w);
      else m_ovf = 1;
      part.delete();
    end
  endtask

  task automatic check_all();
    word_t e;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      e = mq[0];
    end else begin
      e.data = '0; e.keep = '0; e.x = 0; e.y = 0; e.ch = 0;
    end
    chk("out_data", out_data, e.data);
    chk("out_keep", 64'(out_keep), 64'(e.keep));
    chk("out_x", 64'(out_x), 64'(e.x));
    chk("out_y", 64'(out_y), 64'(e.y));
    chk("out_ch", 64'(out_ch), 64'(e.ch));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic feed(input int val, input int x, input int y, input int ch);
    in_valid = 1'b1;
    in_data  = DW'(val);
    in_x = 7'(x); in_y = 7'(y); in_ch = 6'(ch);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b1; in_x = '0; in_y = '0; in_ch = '0;
    relu_en = 1'b0; flush = 1'b1; out_ready = 1'b0;
    px = 0; py = 0; pch = 0; m_ovf = 0;

    // Reset with in_valid and flush held high must leave everything empty
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    tick();

    // Four elements form one word, visible right after the 4th sample
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(i + 1, 5, 6, i);
    chk("w1_valid", 64'(out_valid), 64'd1);
    chk("w1_data", out_data, 64'h0004_0003_0002_0001);
    chk("w1_keep", 64'(out_keep), 64'hF);
    chk("w1_ch", 64'(out_ch), 64'd0);
    tick();

    // ReLU clamp on, then off
    relu_en = 1'b1;
    feed(-5, 1, 1, 0); feed(7, 1, 1, 1); feed(-1, 1, 1, 2); feed(0, 1, 1, 3);
    chk("relu_on", out_data, 64'h0000_0000_0007_0000);
    relu_en = 1'b0;
    feed(-5, 1, 1, 0); feed(7, 1, 1, 1); feed(-1, 1, 1, 2); feed(0, 1, 1, 3);
    chk("relu_off", out_data, 64'h0000_FFFF_0007_FFFB);
    tick();

    // Partial word via flush, then an empty flush emits nothing
    feed(1, 2, 3, 4); feed(2, 2, 3, 5); feed(3, 2, 3, 6);
    flush = 1'b1;
    tick();
    chk("flush_keep", 64'(out_keep), 64'h7);
    chk("flush_data", out_data, 64'h0000_0003_0002_0001);
    tick();
    flush = 1'b0;
    chk("flush2_valid", 64'(out_valid), 64'd0);

    // Flush together with the 4th element yields a single full word
    feed(9, 0, 0, 0); feed(8, 0, 0, 1); feed(7, 0, 0, 2);
    flush = 1'b1;
    feed(6, 0, 0, 3);
    flush = 1'b0;
    chk("flush_full_level", 64'(fifo_level), 64'd1);
    tick();

    // Nine words with no drain: ninth dropped, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 36; i++) feed(100 + i, i % 128, 2, i % 64);
    chk("ovf_level", 64'(fifo_level), 64'd8);
    chk("ovf_set", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO, pop and completing push on the same edge: no drop
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 35; i++) feed(i, 3, 3, i % 64);
    out_ready = 1'b1;
    feed(77, 3, 3, 0);
    chk("simul_level", 64'(fifo_level), 64'd8);
    chk("simul_ovf", 64'(overflow), 64'd0);

    // Reset with partial and queued data, then a clean word
    out_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 14; i++) feed(i + 20, 4, 4, i % 64);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_valid", 64'(out_valid), 64'd0);
    chk("rst2_level", 64'(fifo_level), 64'd0);
    feed(11, 10, 20, 30); feed(12, 10, 20, 31); feed(13, 10, 20, 32); feed(14, 10, 20, 33);
    chk("clean_data", out_data, 64'h000E_000D_000C_000B);
    chk("clean_x", 64'(out_x), 64'd10);

    // Randomised traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_x      = 7'($urandom); in_y = 7'($urandom); in_ch = 6'($urandom);
      relu_en   = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 2) != 0) || (n % 300 < 60 && 0);
      if (n % 400 >= 300) out_ready = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
